// File: rtl/policy_cfg_ctrl.sv
// rtl/policy_cfg_ctrl.sv - AHB-Lite policy table slave with shadow/active copy and sticky lock
`timescale 1ns/1ps
module policy_cfg_ctrl #(
    parameter int NUM_APU_POLICY = 16,
    parameter int NUM_DPU_POLICY = 16
) (
    input  logic                            hclk,
    input  logic                            hreset,
    input  logic                            hsel,
    input  logic [31:0]                     haddr,
    input  logic [31:0]                     hmaster,
    input  logic [2:0]                      hsize,
    input  logic                            hwrite,
    input  logic [31:0]                     hwdata,
    input  logic                            hready,
    output logic [31:0]                     hrdata,
    output logic                            hreadyout,
    output logic                            hresp,
    input  logic                            mon_idle,
    output logic [NUM_APU_POLICY-1:0][31:0] apumid,
    output logic [NUM_APU_POLICY-1:0][31:0] apuaddr,
    output logic [NUM_APU_POLICY-1:0][31:0] apumask,
    output logic [NUM_APU_POLICY-1:0][31:0] apuperm,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpumid,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpuaddr,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpudata,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpumask,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpuamask,
    output logic                            commit_done,
    output logic                            locked
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_COPY = 2'd2
    } state_t;

    state_t state, state_next;

    logic        dp_valid;
    logic        dp_write;
    logic [11:0] dp_addr;
    logic        dp_size_ok;
    logic        dp_priv;
    logic        err2;
    logic [7:0]  err_cnt;

    logic [NUM_APU_POLICY-1:0][31:0] apu_mid_s, apu_addr_s, apu_mask_s, apu_perm_s;
    logic [NUM_DPU_POLICY-1:0][31:0] dpu_mid_s, dpu_addr_s, dpu_data_s, dpu_mask_s, dpu_amask_s;

    logic        aligned, is_ctrl, is_status, apu_hit, dpu_hit, shadow_hit, mapped;
    logic [5:0]  apu_idx;
    logic [6:0]  dpu_idx;
    logic        dp_err, dp_stall, dp_ok, wr_ok, accept, commit_req, copy_en, pending;
    logic [31:0] rdata_mux;

    // Address decode is done in the data phase so the lock state seen is current.
    assign aligned    = (dp_addr[1:0] == 2'b00);
    assign is_ctrl    = (dp_addr == 12'h000);
    assign is_status  = (dp_addr == 12'h004);
    assign apu_idx    = dp_addr[9:4] - 6'd16;
    assign dpu_idx    = dp_addr[11:5] - 7'd32;
    assign apu_hit    = aligned && (dp_addr[11:10] == 2'b00) && (dp_addr[9:8] != 2'b00)
                        && (apu_idx < 6'(NUM_APU_POLICY));
    assign dpu_hit    = aligned && (dp_addr[11:10] != 2'b00) && (dp_addr[4:2] <= 3'd4)
                        && (dpu_idx < 7'(NUM_DPU_POLICY));
    assign shadow_hit = apu_hit || dpu_hit;
    assign mapped     = is_ctrl || is_status || shadow_hit;

    assign dp_err     = dp_valid && (!mapped || !dp_size_ok
                        || (dp_write && (!dp_priv || locked || is_status)));
    assign dp_stall   = dp_valid && !dp_err && dp_write && shadow_hit && (state != ST_IDLE);
    assign dp_ok      = dp_valid && !dp_err && !dp_stall;
    assign wr_ok      = dp_ok && dp_write;

    assign hreadyout  = !(dp_err || dp_stall);
    assign hresp      = dp_err || err2;
    assign accept     = hsel && hready && hreadyout;
    assign commit_req = wr_ok && is_ctrl && hwdata[0];
    assign pending    = (state != ST_IDLE);

    // Active tables load on the PEND->COPY edge so they change with commit_done rising.
    assign copy_en     = (state == ST_PEND) && mon_idle;
    assign commit_done = (state == ST_COPY);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_addr    <= '0;
            dp_size_ok <= 1'b0;
            dp_priv    <= 1'b0;
        end else if (!dp_stall) begin
            dp_valid <= accept;
            if (accept) begin
                dp_write   <= hwrite;
                dp_addr    <= 12'(haddr);
                dp_size_ok <= (hsize == 3'b010);
                dp_priv    <= ((hmaster >> 1) == 32'd0);
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            err2    <= 1'b0;
            err_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            err2 <= dp_err;
            if (dp_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (wr_ok && is_ctrl && hwdata[1]) begin
                locked <= 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (commit_req) state_next = ST_PEND;
            ST_PEND: if (mon_idle) state_next = ST_COPY;
            ST_COPY: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            apu_mid_s   <= '0;
            apu_addr_s  <= '0;
            apu_mask_s  <= '0;
            apu_perm_s  <= '0;
            dpu_mid_s   <= '0;
            dpu_addr_s  <= '0;
            dpu_data_s  <= '0;
            dpu_mask_s  <= '0;
            dpu_amask_s <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_APU_POLICY; i++) begin
                if (apu_hit && (apu_idx == 6'(i))) begin
                    case (dp_addr[3:2])
                        2'd0: apu_mid_s[i]  <= hwdata;
                        2'd1: apu_addr_s[i] <= hwdata;
                        2'd2: apu_mask_s[i] <= hwdata;
                        2'd3: apu_perm_s[i] <= hwdata;
                    endcase
                end
            end
            for (int i = 0; i < NUM_DPU_POLICY; i++) begin
                if (dpu_hit && (dpu_idx == 7'(i))) begin
                    case (dp_addr[4:2])
                        3'd0:    dpu_mid_s[i]   <= hwdata;
                        3'd1:    dpu_addr_s[i]  <= hwdata;
                        3'd2:    dpu_data_s[i]  <= hwdata;
                        3'd3:    dpu_mask_s[i]  <= hwdata;
                        3'd4:    dpu_amask_s[i] <= hwdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            apumid   <= '0;
            apuaddr  <= '0;
            apumask  <= '0;
            apuperm  <= '0;
            dpumid   <= '0;
            dpuaddr  <= '0;
            dpudata  <= '0;
            dpumask  <= '0;
            dpuamask <= '0;
        end else if (copy_en) begin
            apumid   <= apu_mid_s;
            apuaddr  <= apu_addr_s;
            apumask  <= apu_mask_s;
            apuperm  <= apu_perm_s;
            dpumid   <= dpu_mid_s;
            dpuaddr  <= dpu_addr_s;
            dpudata  <= dpu_data_s;
            dpumask  <= dpu_mask_s;
            dpuamask <= dpu_amask_s;
        end
    end

    always_comb begin
        rdata_mux = '0;
        if (dp_ok && !dp_write) begin
            if (is_ctrl) begin
                rdata_mux = {30'd0, locked, pending};
            end else if (is_status) begin
                rdata_mux = {16'd0, err_cnt, 6'd0, locked, pending};
            end else if (apu_hit) begin
                for (int i = 0; i < NUM_APU_POLICY; i++) begin
                    if (apu_idx == 6'(i)) begin
                        case (dp_addr[3:2])
                            2'd0: rdata_mux = apu_mid_s[i];
                            2'd1: rdata_mux = apu_addr_s[i];
                            2'd2: rdata_mux = apu_mask_s[i];
                            2'd3: rdata_mux = apu_perm_s[i];
                        endcase
                    end
                end
            end else if (dpu_hit) begin
                for (int i = 0; i < NUM_DPU_POLICY; i++) begin
                    if (dpu_idx == 7'(i)) begin
                        case (dp_addr[4:2])
                            3'd0:    rdata_mux = dpu_mid_s[i];
                            3'd1:    rdata_mux = dpu_addr_s[i];
                            3'd2:    rdata_mux = dpu_data_s[i];
                            3'd3:    rdata_mux = dpu_mask_s[i];
                            3'd4:    rdata_mux = dpu_amask_s[i];
                            default: rdata_mux = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign hrdata = rdata_mux;

endmodule
